// File: rtl/cpu_axi_pkg.sv
// Shared AXI constants for the CPU subsystem, plus the read-slave FSM
// state type.
//   BURST_*  : ARBURST encodings
//   RESP_*   : RRESP encodings
//   SIZE_4B  : the only ARSIZE the instruction memory serves
package cpu_axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] SIZE_4B     = 3'b010;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } rd_state_t;

   // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/imem_axi_rd_slave_if.sv
// AXI4 read-only bus bundle (AR + R channels).
//   master : drives AR payload/valid and RREADY
//   slave  : drives ARREADY and the R channel
// ARLOCK/ARCACHE/ARPROT/ARQOS/ARUSER are carried but ignored by the slave.
interface imem_axi_rd_slave_if #(
   parameter int ID_W    = 1,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int RUSER_W = 4
);
   logic [ID_W-1:0]    arid;
   logic [ADDR_W-1:0]  araddr;
   logic [7:0]         arlen;
   logic [2:0]         arsize;
   logic [1:0]         arburst;
   logic               arlock;
   logic [3:0]         arcache;
   logic [2:0]         arprot;
   logic [3:0]         arqos;
   logic               aruser;
   logic               arvalid;
   logic               arready;

   logic [ID_W-1:0]    rid;
   logic [DATA_W-1:0]  rdata;
   logic [1:0]         rresp;
   logic               rlast;
   logic [RUSER_W-1:0] ruser;
   logic               rvalid;
   logic               rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arqos, aruser, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, ruser, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arqos, aruser, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, ruser, rvalid
   );
endinterface

// File: rtl/imem_bram.sv
// Simple dual-port RAM, single clock, registered read, read-first.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
// No reset: contents survive a system reset.
module imem_bram #(
   parameter int AWIDTH = 12,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              re,
   input  logic [AWIDTH-1:0] raddr,
   output logic [DWIDTH-1:0] rdata
);
   logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];
   logic [DWIDTH-1:0] rdata_reg;

   // Both accesses are non-blocking on the same edge, so a colliding read
   // sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_reg <= mem[raddr];
   end

   assign rdata = rdata_reg;
endmodule

// File: rtl/imem_axi_rd_slave.sv
// AXI4 read slave in front of a word-addressed instruction memory.
//   CLK, RSTN              : clock, asynchronous active-low reset
//   LD_WE/LD_ADDR/LD_DATA  : loader write port (word index)
//   s_axi                  : AXI read channels (slave modport)
// One burst in flight; FIXED/INCR/WRAP with 32-bit beats. Illegal or
// out-of-range bursts are answered beat-for-beat with SLVERR and zero data.
module imem_axi_rd_slave
   import cpu_axi_pkg::*;
#(
   parameter int          C_S_AXI_THREAD_ID_WIDTH = 1,
   parameter int          C_S_AXI_ADDR_WIDTH      = 32,
   parameter int          C_S_AXI_DATA_WIDTH      = 32,
   parameter int          C_S_AXI_RUSER_WIDTH     = 4,
   parameter logic [31:0] C_BASE_ADDR             = 32'h2000_0000,
   parameter int          C_MEM_AWIDTH            = 12
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic                          LD_WE,
   input  logic [C_MEM_AWIDTH-1:0]       LD_ADDR,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] LD_DATA,
   imem_axi_rd_slave_if.slave            s_axi
);
   localparam int OW = C_S_AXI_ADDR_WIDTH + 2;
   localparam int IW = C_S_AXI_THREAD_ID_WIDTH;
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int MW = C_MEM_AWIDTH;
   localparam logic [OW-1:0] BASE_EXT  = OW'(C_BASE_ADDR);
   localparam logic [OW-1:0] MEM_BYTES = OW'(4) << MW;

   // ---------------- AR decode (two extra bits so nothing overflows) ----
   logic [OW-1:0] addr_ext, off, last_off;
   logic          start_in, end_in, range_ok, ar_err;
   logic [MW-1:0] start_idx;

   assign addr_ext  = OW'(s_axi.araddr);
   assign off       = addr_ext - BASE_EXT;
   assign last_off  = off + OW'({s_axi.arlen, 2'b00});
   assign start_in  = (addr_ext >= BASE_EXT) && (off < MEM_BYTES);
   assign end_in    = last_off < MEM_BYTES;
   // A legal WRAP window is at most 16 aligned words and the memory is an
   // aligned power of two, so a wrap window never leaves memory once its
   // start is inside. Only INCR can run off the end.
   assign range_ok  = start_in && ((s_axi.arburst != BURST_INCR) || end_in);
   assign ar_err    = (s_axi.arsize != SIZE_4B) || (s_axi.araddr[1:0] != 2'b00) ||
                      (s_axi.arburst == BURST_RSVD) ||
                      ((s_axi.arburst == BURST_WRAP) && !wrap_len_ok(s_axi.arlen)) ||
                      !range_ok;
   assign start_idx = off[MW+1:2];

   function automatic logic [MW-1:0] next_idx(input logic [MW-1:0] idx,
                                              input logic [1:0]    burst,
                                              input logic [7:0]    len);
      logic [MW-1:0] mask;
      mask = MW'(len);
      case (burst)
         BURST_FIXED: return idx;
         BURST_WRAP:  return (idx & ~mask) | ((idx + MW'(1)) & mask);
         default:     return idx + MW'(1);
      endcase
   endfunction

   // ---------------- state ----------------
   rd_state_t     state_reg, state_next;
   logic          rst_done_reg;
   logic [IW-1:0] id_reg;
   logic [MW-1:0] idx_reg;
   logic [7:0]    len_reg;
   logic [1:0]    burst_reg;
   logic          err_reg;
   logic [8:0]    issue_cnt_reg;
   logic          pend_reg, pend_last_reg, pend_err_reg;
   logic [DW-1:0] fifo_data_reg [0:1];
   logic          fifo_last_reg [0:1];
   logic          fifo_err_reg  [0:1];
   logic          wr_ptr_reg, rd_ptr_reg;
   logic [1:0]    cnt_reg;

   logic          arready_int, ar_hs, rvalid_int, pop, head_last, room;
   logic          issue, iss_last, iss_err;
   logic [MW-1:0] iss_idx;
   logic [2:0]    occ_after;
   logic [DW-1:0] bram_q;

   assign arready_int = (state_reg == ST_IDLE) && rst_done_reg;
   assign ar_hs       = s_axi.arvalid && arready_int;
   assign rvalid_int  = cnt_reg != 2'd0;
   assign pop         = rvalid_int && s_axi.rready;
   assign head_last   = fifo_last_reg[rd_ptr_reg];
   // Count the beat leaving this cycle so a full-rate stream keeps one
   // read in flight while the other buffer slot drains.
   assign occ_after   = {1'b0, cnt_reg} + {2'b00, pend_reg} - {2'b00, pop};
   assign room        = occ_after < 3'd2;

   // The first read is issued in the AR handshake cycle itself, which puts
   // beat 0 on the R channel two cycles after the handshake.
   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      iss_idx    = idx_reg;
      iss_last   = 1'b0;
      iss_err    = err_reg;
      case (state_reg)
         ST_IDLE: begin
            iss_idx  = start_idx;
            iss_err  = ar_err;
            iss_last = (s_axi.arlen == 8'd0);
            if (ar_hs) begin
               issue      = 1'b1;
               state_next = ST_BURST;
            end
         end
         ST_BURST: begin
            iss_last = (issue_cnt_reg == {1'b0, len_reg});
            if ((issue_cnt_reg <= {1'b0, len_reg}) && room) issue = 1'b1;
            if (pop && head_last) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rst_done_reg  <= 1'b0;
         id_reg        <= '0;
         idx_reg       <= '0;
         len_reg       <= '0;
         burst_reg     <= '0;
         err_reg       <= 1'b0;
         issue_cnt_reg <= '0;
         pend_reg      <= 1'b0;
         pend_last_reg <= 1'b0;
         pend_err_reg  <= 1'b0;
         wr_ptr_reg    <= 1'b0;
         rd_ptr_reg    <= 1'b0;
         cnt_reg       <= '0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_reg[i] <= '0;
            fifo_last_reg[i] <= 1'b0;
            fifo_err_reg[i]  <= 1'b0;
         end
      end else begin
         rst_done_reg <= 1'b1;
         if (ar_hs) begin
            id_reg        <= s_axi.arid;
            len_reg       <= s_axi.arlen;
            burst_reg     <= s_axi.arburst;
            err_reg       <= ar_err;
            idx_reg       <= next_idx(start_idx, s_axi.arburst, s_axi.arlen);
            issue_cnt_reg <= 9'd1;
         end else if (issue) begin
            idx_reg       <= next_idx(idx_reg, burst_reg, len_reg);
            issue_cnt_reg <= issue_cnt_reg + 9'd1;
         end
         pend_reg      <= issue;
         pend_last_reg <= iss_last;
         pend_err_reg  <= iss_err;
         if (pend_reg) begin
            fifo_data_reg[wr_ptr_reg] <= pend_err_reg ? '0 : bram_q;
            fifo_last_reg[wr_ptr_reg] <= pend_last_reg;
            fifo_err_reg[wr_ptr_reg]  <= pend_err_reg;
            wr_ptr_reg                <= ~wr_ptr_reg;
         end
         if (pop) rd_ptr_reg <= ~rd_ptr_reg;
         cnt_reg <= cnt_reg + {1'b0, pend_reg} - {1'b0, pop};
      end
   end

   imem_bram #(.AWIDTH(MW), .DWIDTH(DW)) u_bram (
      .clk   (CLK),
      .we    (LD_WE),
      .waddr (LD_ADDR),
      .wdata (LD_DATA),
      .re    (issue),
      .raddr (iss_idx),
      .rdata (bram_q)
   );

   assign s_axi.arready = arready_int;
   assign s_axi.rvalid  = rvalid_int;
   assign s_axi.rid     = id_reg;
   assign s_axi.rdata   = rvalid_int ? fifo_data_reg[rd_ptr_reg] : '0;
   assign s_axi.rresp   = (rvalid_int && fifo_err_reg[rd_ptr_reg]) ? RESP_SLVERR : RESP_OKAY;
   assign s_axi.rlast   = rvalid_int && head_last;
   assign s_axi.ruser   = '0;

   logic unused_inputs;
   assign unused_inputs = ^{s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                            s_axi.aruser, off[OW-1:MW+2], off[1:0]};
endmodule

// File: doc/imem_axi_rd_slave.md
IMEM_AXI_RD_SLAVE -- requirements
Module: imem_axi_rd_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_THREAD_ID_WIDTH, default 1, meaning width of ARID/RID.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, meaning AXI address width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning AXI data width; only 32 is supported.
REQ-004 SHALL have parameter C_S_AXI_RUSER_WIDTH, default 4, meaning RUSER width.
REQ-005 SHALL have parameter C_BASE_ADDR, default 32'h2000_0000, meaning byte address of word 0.
REQ-006 SHALL have parameter C_MEM_AWIDTH, default 12, meaning log2 of memory depth in 32-bit words.
REQ-007 SHALL use one clock and an asynchronous, active-low reset; ports are listed below as name, direction, width, meaning.
REQ-008 CLK  in  1  clock; all logic is rising-edge.
REQ-009 RSTN  in  1  asynchronous active-low reset.
REQ-010 LD_WE  in  1  loader write enable.
REQ-011 LD_ADDR  in  C_MEM_AWIDTH  loader word index.
REQ-012 LD_DATA  in  32  loader write data.
REQ-013 S_AXI_ARID, ARADDR, ARLEN[8], ARSIZE[3], ARBURST[2], ARVALID  in  AR channel inputs; ARLOCK, ARCACHE, ARPROT, ARQOS and ARUSER are inputs that are ignored.
REQ-014 S_AXI_ARREADY  out  1  address accept.
REQ-015 S_AXI_RID, RDATA[32], RRESP[2], RLAST, RUSER, RVALID  out  R channel outputs; S_AXI_RREADY  in  1.

Function
REQ-016 SHALL accept one AR transaction at a time; ARREADY=1 only in state IDLE.
REQ-017 SHALL implement the FSM IDLE -> BURST on ARVALID&&ARREADY, and BURST -> IDLE on the handshake of the beat with RLAST=1.
REQ-018 SHALL latch ARID, the start word index (ARADDR-C_BASE_ADDR)>>2, beat count ARLEN+1, ARBURST and the error flag at AR handshake.
REQ-019 SHALL set the error flag when any of the following holds: ARSIZE!=3'b010; ARADDR[1:0]!=0; ARBURST==2'b11; ARBURST==WRAP with ARLEN not in {1,3,7,15}; or any beat address lies outside [C_BASE_ADDR, C_BASE_ADDR+4*2^C_MEM_AWIDTH).
REQ-020 SHALL respond to an error burst with ARLEN+1 beats, each with RRESP=2'b10 and RDATA=0; otherwise RRESP=2'b00.
REQ-021 Beat address: FIXED holds the start address; INCR adds 1 word per beat; WRAP wraps within an aligned (ARLEN+1)-word window.
REQ-022 SHALL read memory synchronously with 1-cycle latency; the first RVALID SHALL be asserted 2 cycles after the AR handshake cycle.
REQ-023 SHALL sustain 1 beat per cycle while RREADY=1, using a 2-entry output buffer (skid).
REQ-024 While RVALID=1 && RREADY=0, RDATA, RID, RRESP and RLAST SHALL hold stable and RVALID SHALL stay 1.
REQ-025 RLAST SHALL be 1 only on beat ARLEN+1; RID SHALL equal the latched ARID; RUSER SHALL be 0.
REQ-026 On a loader write and an AXI read of the same word in the same cycle, the read SHALL return the old data (read-first).
REQ-027 A new AR SHALL be accepted no earlier than the cycle after the RLAST handshake.

Reset
REQ-028 While RSTN=0: FSM=IDLE, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, and the buffer is empty; memory contents are unchanged.
REQ-029 RSTN asserted mid-burst SHALL abandon the burst immediately; no further beats are issued after release.
REQ-030 ARREADY SHALL rise in the first cycle after RSTN is released.

Structure
REQ-031 AXI constants (BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, SIZE_4B) SHALL live in the shared package cpu_axi_pkg.
REQ-032 Memory SHALL be a sub-module imem_bram: single clock, one read port, one write port, read-first.

Verification
REQ-033 Load word i = 0x1000_0000+i for i=0..15; AR at 0x2000_0000, INCR, ARLEN=3, RREADY=1 -> RDATA 0x1000_0000..0x1000_0003 on consecutive cycles, first beat 2 cycles after AR, RLAST on beat 4, RRESP=0.
REQ-034 Same burst with RREADY toggled 1,0,0,1,... -> no beat lost or duplicated, and outputs stable while stalled.
REQ-035 WRAP, ARLEN=3, ARADDR=0x2000_0008 -> data for words 2,3,0,1.
REQ-036 ARADDR=0x1FFF_FFFC, ARLEN=1 -> 2 beats, RRESP=2'b10, RDATA=0, RLAST on beat 2.
REQ-037 RSTN pulsed low after beat 2 of an ARLEN=7 burst -> RVALID drops immediately, no further beats; a new AR is accepted after release and returns correct data.
REQ-038 LD_WE writes 0xDEAD_BEEF to word 5 in the same cycle the AXI read of word 5 is issued -> old value returned; a re-read returns 0xDEAD_BEEF.
